// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Audio back end of the tug-of-war sound path. On a start
//                request it plays one of four fixed note sequences as a
//                square wave on the speaker pin, separated by short silent
//                gaps, then pulses done and returns to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
    parameter int TONE_SCALE = 1000,
    parameter int MS_DIV     = 100000,
    parameter int GAP_MS     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sound_type,
    output logic       audio,
    output logic       amp_en,
    output logic       busy,
    output logic       done,
    output logic [1:0] note_idx
);

    // Counter widths: the tone counter must hold the longest half-period
    // terminal (note C), the prescaler must hold MS_DIV-1.
    localparam int c_TONE_MAX = 191 * TONE_SCALE;
    localparam int c_TW       = (c_TONE_MAX > 1) ? $clog2(c_TONE_MAX) : 1;
    localparam int c_PW       = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int c_DW       = 9;

    // Exact terminal values; all comparisons are equality on these.
    localparam logic [c_TW-1:0] c_TERM_C  = c_TW'(191 * TONE_SCALE - 1);
    localparam logic [c_TW-1:0] c_TERM_E  = c_TW'(152 * TONE_SCALE - 1);
    localparam logic [c_TW-1:0] c_TERM_G  = c_TW'(128 * TONE_SCALE - 1);
    localparam logic [c_TW-1:0] c_TERM_CH = c_TW'(96 * TONE_SCALE - 1);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(MS_DIV - 1);
    localparam logic [c_DW-1:0] c_GAP_LAST = c_DW'(GAP_MS - 1);

    // Note codes used by the sequence ROM
    localparam logic [1:0] c_NOTE_C  = 2'd0;
    localparam logic [1:0] c_NOTE_E  = 2'd1;
    localparam logic [1:0] c_NOTE_G  = 2'd2;
    localparam logic [1:0] c_NOTE_CH = 2'd3;

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PLAY = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [1:0]      r_type;
    logic [1:0]      r_note;
    logic [c_TW-1:0] r_tone;
    logic [c_PW-1:0] r_pre;
    logic [c_DW-1:0] r_dur;
    logic            r_audio;

    logic [1:0]      w_note;
    logic [c_DW-1:0] w_note_ms;
    logic [c_TW-1:0] w_tone_term;
    logic            w_tick;
    logic            w_last;
    logic            w_note_end;
    logic            w_gap_end;
    logic            w_active;
    logic            w_load;

    // Sequence ROM: note and duration (ms) for the current type/index.
    always_comb begin
        w_note    = c_NOTE_C;
        w_note_ms = 9'd40;
        case (r_type)
            2'd0: begin
                w_note    = c_NOTE_C;
                w_note_ms = 9'd40;
            end
            2'd1: begin
                w_note    = (r_note == 2'd0) ? c_NOTE_E : c_NOTE_G;
                w_note_ms = 9'd100;
            end
            2'd2: begin
                w_note    = (r_note == 2'd1) ? c_NOTE_E : c_NOTE_G;
                w_note_ms = 9'd60;
            end
            default: begin
                w_note_ms = (r_note == 2'd3) ? 9'd300 : 9'd150;
                case (r_note)
                    2'd0:    w_note = c_NOTE_C;
                    2'd1:    w_note = c_NOTE_E;
                    2'd2:    w_note = c_NOTE_G;
                    default: w_note = c_NOTE_CH;
                endcase
            end
        endcase
    end

    // Half-period terminal count for the current note.
    always_comb begin
        w_tone_term = c_TERM_C;
        case (w_note)
            c_NOTE_C:  w_tone_term = c_TERM_C;
            c_NOTE_E:  w_tone_term = c_TERM_E;
            c_NOTE_G:  w_tone_term = c_TERM_G;
            default:   w_tone_term = c_TERM_CH;
        endcase
    end

    // A note or gap ends on the ms tick that completes its last millisecond,
    // so a note of N ms occupies exactly N*MS_DIV cycles.
    assign w_tick     = (r_pre == c_PRE_LAST);
    assign w_last     = (r_note == r_type);
    assign w_note_end = w_tick && (r_dur == (w_note_ms - 9'd1));
    assign w_gap_end  = w_tick && (r_dur == c_GAP_LAST);
    assign w_active   = (r_state == c_ST_PLAY) || (r_state == c_ST_GAP);

    // Accept a request when idle/finishing, or preempt with a higher type.
    assign w_load = start && (!w_active || (sound_type > r_type));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_load) w_next = c_ST_PLAY;
            end
            c_ST_PLAY: begin
                if (w_load)          w_next = c_ST_PLAY;
                else if (w_note_end) w_next = w_last ? c_ST_DONE : c_ST_GAP;
            end
            c_ST_GAP: begin
                if (w_load || w_gap_end) w_next = c_ST_PLAY;
            end
            c_ST_DONE: begin
                w_next = w_load ? c_ST_PLAY : c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // Datapath: type latch, note index, tone/prescaler/duration counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_type  <= 2'd0;
            r_note  <= 2'd0;
            r_tone  <= '0;
            r_pre   <= '0;
            r_dur   <= '0;
            r_audio <= 1'b0;
        end else if (w_load) begin
            r_type  <= sound_type;
            r_note  <= 2'd0;
            r_tone  <= '0;
            r_pre   <= '0;
            r_dur   <= '0;
            r_audio <= 1'b0;
        end else begin
            case (r_state)
                c_ST_PLAY: begin
                    if (w_note_end) begin
                        r_tone  <= '0;
                        r_pre   <= '0;
                        r_dur   <= '0;
                        r_audio <= 1'b0;
                    end else begin
                        if (r_tone == w_tone_term) begin
                            r_tone  <= '0;
                            r_audio <= ~r_audio;
                        end else begin
                            r_tone <= r_tone + c_TW'(1);
                        end
                        if (w_tick) begin
                            r_pre <= '0;
                            r_dur <= r_dur + 9'd1;
                        end else begin
                            r_pre <= r_pre + c_PW'(1);
                        end
                    end
                end
                c_ST_GAP: begin
                    r_tone  <= '0;
                    r_audio <= 1'b0;
                    if (w_gap_end) begin
                        r_note <= r_note + 2'd1;
                        r_pre  <= '0;
                        r_dur  <= '0;
                    end else if (w_tick) begin
                        r_pre <= '0;
                        r_dur <= r_dur + 9'd1;
                    end else begin
                        r_pre <= r_pre + c_PW'(1);
                    end
                end
                default: begin
                    r_note  <= 2'd0;
                    r_tone  <= '0;
                    r_pre   <= '0;
                    r_dur   <= '0;
                    r_audio <= 1'b0;
                end
            endcase
        end
    end

    // Output decode: state-qualified so reset silences everything at once.
    always_comb begin
        audio  = 1'b0;
        amp_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            c_ST_PLAY: begin
                audio  = r_audio;
                amp_en = 1'b1;
                busy   = 1'b1;
            end
            c_ST_GAP: begin
                amp_en = 1'b1;
                busy   = 1'b1;
            end
            c_ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign note_idx = r_note;

endmodule
`default_nettype wire
